// File: rtl/decode_pkg.sv
// Shared layout of the decoded-instruction bundle between decode stage 2 and issue.
// Format codes, field widths/offsets, and pack/unpack helpers.
package decode_pkg;

  localparam int unsigned OpcodeW  = 6;
  localparam int unsigned RegW     = 5;
  localparam int unsigned XOpcodeW = 10;
  localparam int unsigned AddrW    = 64;
  localparam int unsigned FuW      = 2;
  localparam int unsigned FormatW  = 5;
  localparam int unsigned ImmW     = 64;
  localparam int unsigned PayloadW = 177;

  typedef enum logic [FormatW-1:0] {
    FmtA = 5'd0, FmtB, FmtD, FmtDq, FmtDs, FmtDx, FmtI, FmtM, FmtMd, FmtMds, FmtSc,
    FmtVa, FmtVc, FmtVx, FmtX, FmtXfl, FmtXfx, FmtXl, FmtXo, FmtXs, FmtXx2, FmtXx3,
    FmtXx4, FmtZ22, FmtZ23, FmtInvalid = 5'd31
  } format_e;

  // LSB offsets of each field inside the packed bundle.
  localparam int unsigned FormatLsb        = 0;
  localparam int unsigned FuLsb            = 5;
  localparam int unsigned XOpcodeEnBit     = 7;
  localparam int unsigned XOpcodeLsb       = 8;
  localparam int unsigned OpcodeLsb        = 18;
  localparam int unsigned AddrLsb          = 24;
  localparam int unsigned Reg2ValOrZeroBit = 88;
  localparam int unsigned Bit2EnBit        = 89;
  localparam int unsigned Bit1EnBit        = 90;
  localparam int unsigned Bit2Bit          = 91;
  localparam int unsigned Bit1Bit          = 92;
  localparam int unsigned Reg3IsImmBit     = 93;
  localparam int unsigned Reg3EnBit        = 94;
  localparam int unsigned Reg2EnBit        = 95;
  localparam int unsigned Reg1EnBit        = 96;
  localparam int unsigned Reg3Lsb          = 97;
  localparam int unsigned Reg2Lsb          = 102;
  localparam int unsigned Reg1Lsb          = 107;
  localparam int unsigned ImmEnBit         = 112;
  localparam int unsigned ImmLsb           = 113;

  // Member order is MSB first, so the struct bit layout matches the offsets above.
  typedef struct packed {
    logic [ImmW-1:0]     imm;
    logic                imm_enable;
    logic [RegW-1:0]     reg1;
    logic [RegW-1:0]     reg2;
    logic [RegW-1:0]     reg3;
    logic                reg1_enable;
    logic                reg2_enable;
    logic                reg3_enable;
    logic                reg3_is_immediate;
    logic                bit1;
    logic                bit2;
    logic                bit1_enable;
    logic                bit2_enable;
    logic                reg2_val_or_zero;
    logic [AddrW-1:0]    instruction_address;
    logic [OpcodeW-1:0]  opcode;
    logic [XOpcodeW-1:0] x_opcode;
    logic                x_opcode_enable;
    logic [FuW-1:0]      functional_unit_code;
    logic [FormatW-1:0]  instruction_format;
  } decode_bundle_t;

  function automatic logic [PayloadW-1:0] pack_bundle(decode_bundle_t b);
    return PayloadW'(b);
  endfunction

  function automatic decode_bundle_t unpack_bundle(logic [PayloadW-1:0] v);
    return decode_bundle_t'(v);
  endfunction

endpackage

// File: rtl/decode_issue_queue_if.sv
// Decode-to-issue queue bus: push side from decode, pop side to issue, status flags.
interface decode_issue_queue_if #(
  parameter int unsigned PtrW = 2
);
  logic                          enable;
  logic [decode_pkg::PayloadW-1:0] instr_in;
  logic                          flush;
  logic                          ready;
  logic                          valid;
  logic [decode_pkg::PayloadW-1:0] instr_out;
  logic                          stall;
  logic                          almost_full;
  logic [PtrW:0]                 count;
  logic                          overflow;

  modport master (
    output enable, instr_in, flush, ready,
    input  valid, instr_out, stall, almost_full, count, overflow
  );

  modport slave (
    input  enable, instr_in, flush, ready,
    output valid, instr_out, stall, almost_full, count, overflow
  );
endinterface

// File: rtl/queue_storage.sv
// Unreset register array: one synchronous write port, one asynchronous read port.
module queue_storage #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 2,
  parameter int unsigned Width = 177
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/decode_issue_queue.sv
// Elastic FIFO between decode stage 2 and issue; flags come from registered count only,
// so a full queue rejects a push even when the head pops in the same cycle.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned PtrW          = 2,
  parameter int unsigned AlmostFullLvl = 3
) (
  input logic                 clock_i,
  input logic                 reset_i,
  decode_issue_queue_if.slave q_if
);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);
  localparam logic [PtrW:0] AfCnt    = (PtrW+1)'(AlmostFullLvl);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, not_empty, push, pop;

  always_comb begin
    full      = (count_q == DepthCnt);
    not_empty = (count_q != '0);
    push      = q_if.enable & ~full & ~q_if.flush;
    pop       = not_empty & q_if.ready & ~q_if.flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (q_if.enable & full & ~q_if.flush);

    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + (PtrW+1)'(1);
      else if (pop && !push) count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  queue_storage #(
    .Depth (Depth),
    .AddrW (PtrW),
    .Width (PayloadW)
  ) u_storage (
    .clk_i   (clock_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (q_if.instr_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (q_if.instr_out)
  );

  assign q_if.valid       = not_empty;
  assign q_if.stall       = full;
  assign q_if.almost_full = (count_q >= AfCnt);
  assign q_if.count       = count_q;
  assign q_if.overflow    = overflow_q;
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Elastic FIFO between the decode mux stage (stage 2) and the issue/register-read stage.
- Captures the registered, single-bus decoded instruction bundle each cycle its enable is high, and buffers up to DEPTH entries.
- Presents the oldest entry to issue with a valid/ready handshake.
- Back-pressures decode through stall_o, and supports a pipeline flush on branch redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).
- PAYLOAD_W, 177, width of the packed decoded-instruction bundle; field layout is defined in the package.
- ALMOST_FULL_LVL, 3, occupancy at or above which almostFull_o asserts.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  decode stage 2 has a valid instruction this cycle (push request).
- instr_i  in  PAYLOAD_W  packed bundle. Fields, MSB first: imm 64, immEnable 1, reg1/reg2/reg3 5 each, reg1/2/3Enable 3, reg3IsImmediate 1, bit1/bit2 2, bit1/2Enable 2, reg2ValOrZero 1, instructionAddress 64, opcode 6, xOpcode 10, xOpcodeEnable 1, functionalUnitCode 2, instructionFormat 5.
- flush_i  in  1  discard all queued entries.
- ready_i  in  1  issue stage accepts the head entry this cycle.
- valid_o  out  1  head entry is valid.
- instr_o  out  PAYLOAD_W  head entry payload.
- stall_o  out  1  queue full; decode must hold.
- almostFull_o  out  1  count >= ALMOST_FULL_LVL.
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a push was attempted while full.

Behaviour:
- Reset (reset_i=1 at clock edge):
  - wrPtr, rdPtr, count = 0.
  - valid_o=0, stall_o=0, almostFull_o=0, count_o=0, overflow_o=0.
  - Storage array is not reset; instr_o is don't-care while valid_o=0.
  - Reset has priority over every other input.
- Push accepted iff enable_i=1, count<DEPTH and flush_i=0.
  - Writes instr_i to mem[wrPtr]; wrPtr increments modulo DEPTH (natural wrap).
- Pop occurs iff valid_o=1, ready_i=1 and flush_i=0.
  - rdPtr increments modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, a push is rejected even if a pop occurs the same cycle, because stall_o is derived from registered count. The popped entry still leaves.
- Push attempted while full with no flush sets overflow_o. It stays set until reset. This is a protocol error flag for verification; the instruction is dropped.
- Output timing:
  - valid_o = (count != 0), decoded from registered state.
  - instr_o = mem[rdPtr], read combinationally from storage.
  - Latency: an instruction pushed at edge N is visible with valid_o=1 after edge N. No same-cycle bypass.
- stall_o = (count == DEPTH). almostFull_o = (count >= ALMOST_FULL_LVL). Both come from registered count only, never from ready_i.
- flush_i=1 at an edge:
  - wrPtr, rdPtr, count = 0; valid_o=0 next cycle.
  - Same-cycle push and pop are ignored.
  - overflow_o is kept.
- Ready is honoured only while valid: ready_i when empty has no effect.
- Payload ordering is strictly FIFO. Fields are not modified or interpreted.

Decomposition:
- Shared package decode_pkg holds:
  - the format constants A..Z23 and INVALID (5-bit);
  - the field widths (opcode 6, reg 5, xOpcode 10, address 64, functional unit 2);
  - the field offsets within the packed bundle, with PAYLOAD_W = 177;
  - a pack/unpack function pair, so decode stage 2 and issue share one layout.
- One natural sub-module: queue_storage, the DEPTH x PAYLOAD_W register array with one write port and one async read port.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset then idle: hold reset_i 2 cycles, then enable_i=0 for 5 cycles -> valid_o=0, count_o=0, stall_o=0, overflow_o=0 throughout.
- Single pass: push a bundle with instructionAddress=0x1000, opcode=14, imm=0xFFFF_FFFF_FFFF_FFFC, with ready_i=0 -> next cycle valid_o=1, instr_o equals the bundle, count_o=1; set ready_i=1 -> following cycle valid_o=0.
- Fill and back-pressure: ready_i=0, push addresses 0x0, 0x4, 0x8, 0xC -> count_o 1,2,3,4; almostFull_o rises at count 3; stall_o=1 at count 4. A 5th push (0x10) sets overflow_o=1 and count stays 4. Drain with ready_i=1 -> order 0x0, 0x4, 0x8, 0xC.
- Wrap and concurrency: after 3 pushes/pops move pointers to 3, hold enable_i=1 and ready_i=1 for 8 cycles with addresses 0x100..0x11C -> count_o constant at 1, outputs in order with a one-cycle lag, no loss across pointer wrap.
- Flush mid-stream: with count_o=3, assert flush_i together with enable_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0; the pushed instruction is discarded; a subsequent push of 0x200 appears at the head.
- Reset mid-operation: with count_o=4 and overflow_o=1, assert reset_i for one cycle -> all outputs return to reset values, including overflow_o=0.
